// File: rtl/game_pkg.sv
// Shared types, default constants and BCD helpers for the game sequencer.
// Optional hiscore support is enabled by defining GAME_SEQ_HISCORE_EN.
`timescale 1ns/1ps
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    PLAY   = 3'd2,
    CRASH  = 3'd3,
    OVER   = 3'd4
  } state_t;

  typedef logic [3:0] bcd_digit_t;
  // Index 3 is the thousands digit, index 0 the units digit.
  typedef bcd_digit_t [3:0] bcd4_t;

  localparam int unsigned TICK_W_DEF     = 6;
  localparam int unsigned CRASH_HOLD_DEF = 50;
  localparam int unsigned LEVEL_STEP_DEF = 5;
  localparam int unsigned MAX_LEVEL_DEF  = 7;
  localparam int unsigned LEVEL_W        = 3;
  localparam int unsigned SCORE_W        = 16;

  function automatic bcd4_t bcd_inc(input bcd4_t v);
    bcd4_t r;
    logic  carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = r[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Digit-wise magnitude compare starting from the thousands digit.
  function automatic logic bcd_gt(input bcd4_t a, input bcd4_t b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a[i] != b[i])) begin
        gt      = (a[i] > b[i]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/game_sequencer_bcd_counter4.sv
// 4-digit BCD counter saturating at 9999; the compare output exists only
// when GAME_SEQ_HISCORE_EN is defined.
`timescale 1ns/1ps
module bcd_counter4
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clr,
  input  logic  inc,
`ifdef GAME_SEQ_HISCORE_EN
  input  bcd4_t cmp_ref,
  output logic  cmp_gt_c,
`endif
  output bcd4_t count
);

  localparam bcd4_t BCD_MAX = 16'h9999;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != BCD_MAX)) begin
      count <= bcd_inc(count);
    end
  end

`ifdef GAME_SEQ_HISCORE_EN
  assign cmp_gt_c = bcd_gt(count, cmp_ref);
`endif

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer for the bird/tube game: start, play, crash hold, game over.
// Define GAME_SEQ_HISCORE_EN to add the hiscore register and show_hi input.
`timescale 1ns/1ps
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_W     = TICK_W_DEF,
  parameter int unsigned CRASH_HOLD = CRASH_HOLD_DEF,
  parameter int unsigned LEVEL_STEP = LEVEL_STEP_DEF,
  parameter int unsigned MAX_LEVEL  = MAX_LEVEL_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_tick,
  input  logic               start_btn,
  input  logic               tube_cycle,
  input  logic               crash,
`ifdef GAME_SEQ_HISCORE_EN
  input  logic               show_hi,
  output logic [SCORE_W-1:0] hiscore,
`endif
  output logic               tube_start,
  output logic               run,
  output logic               freeze,
  output logic [LEVEL_W-1:0] level,
  output logic [SCORE_W-1:0] score,
  output logic               state_led
);

  localparam int unsigned STEP_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

  state_t              state, state_d;
  logic                start_q;
  logic                start_rise_c;
  logic [TICK_W-1:0]   hold, hold_d;
  logic [STEP_W-1:0]   step, step_d;
  logic [LEVEL_W-1:0]  level_d;
  logic [2:0]          blink, blink_d;
  logic                score_inc_c, score_clr_c;
  logic                tube_start_d, run_d, freeze_d, led_d;
  bcd4_t               count;

  assign start_rise_c = start_btn & ~start_q;

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state;
    hold_d      = hold;
    step_d      = step;
    level_d     = level;
    blink_d     = blink;
    score_inc_c = 1'b0;
    score_clr_c = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise_c) state_d = LAUNCH;
      end
      LAUNCH: begin
        score_clr_c = 1'b1;
        level_d     = '0;
        step_d      = '0;
        state_d     = PLAY;
      end
      PLAY: begin
        // A crash in the same clk as a tube pass forfeits that point.
        if (crash) begin
          state_d = CRASH;
          hold_d  = '0;
        end else if (tube_cycle) begin
          score_inc_c = 1'b1;
          if (step == STEP_W'(LEVEL_STEP - 1)) begin
            step_d = '0;
            if (level != LEVEL_W'(MAX_LEVEL)) level_d = level + LEVEL_W'(1);
          end else begin
            step_d = step + STEP_W'(1);
          end
        end
      end
      CRASH: begin
        if (game_tick) begin
          if (hold == TICK_W'(CRASH_HOLD - 1)) begin
            state_d = OVER;
            blink_d = '0;
          end else begin
            hold_d = hold + TICK_W'(1);
          end
        end
      end
      OVER: begin
        if (game_tick) blink_d = blink + 3'd1;
        if (start_rise_c) state_d = LAUNCH;
      end
      default: state_d = IDLE;
    endcase
    tube_start_d = (state_d == LAUNCH);
    run_d        = (state_d == PLAY);
    freeze_d     = (state_d == CRASH) || (state_d == OVER);
    led_d        = (state_d == OVER) ? blink_d[2] : run_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      hold       <= '0;
      step       <= '0;
      level      <= '0;
      blink      <= '0;
      tube_start <= 1'b0;
      run        <= 1'b0;
      freeze     <= 1'b0;
      state_led  <= 1'b0;
    end else begin
      state      <= state_d;
      start_q    <= start_btn;
      hold       <= hold_d;
      step       <= step_d;
      level      <= level_d;
      blink      <= blink_d;
      tube_start <= tube_start_d;
      run        <= run_d;
      freeze     <= freeze_d;
      state_led  <= led_d;
    end
  end

`ifdef GAME_SEQ_HISCORE_EN
  logic  hi_gt_c;
  logic  sel_hi;
  bcd4_t hi_q;

  bcd_counter4 u_score (
    .clk      (clk),
    .reset    (reset),
    .clr      (score_clr_c),
    .inc      (score_inc_c),
    .cmp_ref  (hi_q),
    .cmp_gt_c (hi_gt_c),
    .count    (count)
  );

  // Hiscore is captured on the CRASH->OVER transition only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      sel_hi <= 1'b0;
    end else begin
      if ((state == CRASH) && (state_d == OVER) && hi_gt_c) hi_q <= count;
      sel_hi <= show_hi && ((state_d == IDLE) || (state_d == OVER));
    end
  end

  assign hiscore = hi_q;
  assign score   = sel_hi ? hi_q : count;
`else
  bcd_counter4 u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr_c),
    .inc   (score_inc_c),
    .count (count)
  );

  assign score = count;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized self-checking bench for game_sequencer against a decimal-score
// round model; covers the hiscore path when GAME_SEQ_HISCORE_EN is defined.
`timescale 1ns/1ps
module tb_game_sequencer;

  localparam int P_IDLE = 0, P_LAUNCH = 1, P_PLAY = 2, P_CRASH = 3, P_OVER = 4;
  localparam int HOLD_TICKS = 50;
  localparam int STEP_TUBES = 5;
  localparam int TOP_LEVEL  = 7;
`ifdef GAME_SEQ_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        game_tick, start_btn, tube_cycle, crash;
  logic        tube_start, run, freeze, state_led;
  logic [2:0]  level;
  logic [15:0] score;
`ifdef GAME_SEQ_HISCORE_EN
  logic        show_hi;
  logic [15:0] hiscore;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_phase, m_score, m_passed, m_ticks, m_hi;
  bit m_prev, m_show, sh_drv;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .game_tick  (game_tick),
    .start_btn  (start_btn),
    .tube_cycle (tube_cycle),
    .crash      (crash),
`ifdef GAME_SEQ_HISCORE_EN
    .show_hi    (show_hi),
    .hiscore    (hiscore),
`endif
    .tube_start (tube_start),
    .run        (run),
    .freeze     (freeze),
    .level      (level),
    .score      (score),
    .state_led  (state_led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_score = 0; m_passed = 0; m_ticks = 0;
    m_hi = 0; m_prev = 1'b0; m_show = 1'b0;
  endtask

  // Applies the round rules for one clk with the given inputs.
  task automatic model_clk(input bit btn, input bit tc, input bit cr, input bit gt, input bit sh);
    bit rise;
    rise   = btn && !m_prev;
    m_prev = btn;
    case (m_phase)
      P_IDLE:   if (rise) m_phase = P_LAUNCH;
      P_LAUNCH: begin m_score = 0; m_passed = 0; m_phase = P_PLAY; end
      P_PLAY: begin
        if (cr) begin
          m_phase = P_CRASH; m_ticks = 0;
        end else if (tc) begin
          if (m_score < 9999) m_score++;
          m_passed++;
        end
      end
      P_CRASH: begin
        if (gt) begin
          m_ticks++;
          if (m_ticks == HOLD_TICKS) begin
            m_phase = P_OVER; m_ticks = 0;
            if (m_score > m_hi) m_hi = m_score;
          end
        end
      end
      P_OVER: begin
        if (gt) m_ticks++;
        if (rise) m_phase = P_LAUNCH;
      end
      default: m_phase = P_IDLE;
    endcase
    m_show = HI_EN && sh && (m_phase == P_IDLE || m_phase == P_OVER);
  endtask

  task automatic compare_all();
    int exp_lvl;
    bit exp_run, exp_led;
    exp_lvl = m_passed / STEP_TUBES;
    if (exp_lvl > TOP_LEVEL) exp_lvl = TOP_LEVEL;
    exp_run = (m_phase == P_PLAY);
    exp_led = (m_phase == P_OVER) ? bit'((m_ticks / 4) % 2) : exp_run;
    check("tube_start", 32'(tube_start), 32'(m_phase == P_LAUNCH));
    check("run", 32'(run), 32'(exp_run));
    check("freeze", 32'(freeze), 32'(m_phase == P_CRASH || m_phase == P_OVER));
    check("level", 32'(level), 32'(exp_lvl));
    check("score", 32'(score), 32'(m_show ? to_bcd(m_hi) : to_bcd(m_score)));
    check("state_led", 32'(state_led), 32'(exp_led));
`ifdef GAME_SEQ_HISCORE_EN
    check("hiscore", 32'(hiscore), 32'(to_bcd(m_hi)));
`endif
  endtask

  task automatic step(input bit btn, input bit tc, input bit cr, input bit gt);
    start_btn = btn; tube_cycle = tc; crash = cr; game_tick = gt;
`ifdef GAME_SEQ_HISCORE_EN
    show_hi = sh_drv;
`endif
    model_clk(btn, tc, cr, gt, sh_drv);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic play_round(input int n);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int t = 0; t < HOLD_TICKS; t++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; start_btn = 1'b0; tube_cycle = 1'b0; crash = 1'b0; game_tick = 1'b0;
    sh_drv = 1'b0;
`ifdef GAME_SEQ_HISCORE_EN
    show_hi = 1'b0;
`endif
    model_reset();
    #23;
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle with no start request
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    check("idle_score", 32'(score), 32'h0);

    // Start edge launches exactly one tube_start pulse
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("launch_pulse", 32'(tube_start), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("launch_once", 32'(tube_start), 32'h0);
    check("run_after_launch", 32'(run), 32'h1);

    // Twelve passed tubes with random gaps
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    check("score_12", 32'(score), 32'h0012);
    check("level_2", 32'(level), 32'h2);

    // Crash beats a simultaneous tube pass; start held through crash/over
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("crash_no_inc", 32'(score), 32'h0012);
    check("crash_freeze", 32'(freeze), 32'h1);
    for (int t = 0; t < HOLD_TICKS; t++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    check("over_held_no_restart", 32'(tube_start), 32'h0);
    check("over_score_hold", 32'(score), 32'h0012);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_pulse", 32'(tube_start), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_score_clr", 32'(score), 32'h0);
    check("restart_level_clr", 32'(level), 32'h0);

    // Digit carry and saturation
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("score_0009", 32'(score), 32'h0009);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("score_0010", 32'(score), 32'h0010);
    for (int i = 0; i < 9989; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    check("score_9999", 32'(score), 32'h9999);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("score_sat", 32'(score), 32'h9999);
    check("level_sat", 32'(level), 32'h7);

    // Asynchronous reset mid-round
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_score", 32'(score), 32'h0);
    check("async_rst_run", 32'(run), 32'h0);
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef GAME_SEQ_HISCORE_EN
    play_round(15);
    play_round(7);
    check("hiscore_15", 32'(hiscore), 32'h0015);
    check("score_round2", 32'(score), 32'h0007);
    sh_drv = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("show_hi_over", 32'(score), 32'h0015);
    sh_drv = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("show_hi_off", 32'(score), 32'h0007);
`else
    play_round(15);
    check("round_score_15", 32'(score), 32'h0015);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit btn;
      btn    = ($urandom_range(0, 9) == 0) ? !m_prev : m_prev;
      sh_drv = 1'($urandom_range(0, 1));
      step(btn, ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
